// File: rtl/lsu_bus_controller.sv
// lsu_bus_controller: MEM-stage load/store sequencer issuing one valid/ready data-bus transaction per access.
// Optional define MISALIGN_TRAP_EN: misaligned H/W accesses are trapped instead of force-aligned.
module lsu_bus_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  StrobeM,
   input  logic [31:0] AddrM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        BusErrM,
   output logic        MisalignM,
   output logic        BusValid,
   output logic        BusWrite,
   output logic [31:0] BusAddr,
   output logic [3:0]  BusByteEn,
   output logic [31:0] BusWData,
   input  logic        BusReady,
   input  logic [31:0] BusRData
);

   // state  | meaning
   // S_IDLE | no access pending; a new MEM-stage request is sampled here
   // S_REQ  | BusValid high, waiting for BusReady or timeout
   // S_DONE | access finished; pipeline released for one cycle

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYCLES);

   state_t      state;
   state_t      state_nxt;
   logic        req;
   logic        is_byte;
   logic        is_half;
   logic        misaligned;
   logic [1:0]  off;
   logic [3:0]  byte_en;
   logic [31:0] wdata;
   logic        issue;
   logic        complete;
   logic        timeout;
   logic [7:0]  tmr;
   logic        tmr_tc;
   logic [1:0]  ld_off;
   logic        ld_byte;
   logic        ld_half;
   logic        ld_unsigned;
   logic [31:0] ld_shift;
   logic [31:0] ld_ext;

   assign req     = MemReadM | MemWriteM;
   assign is_byte = (StrobeM[1:0] == 2'b00);
   assign is_half = (StrobeM[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
   assign misaligned = (is_half & AddrM[0]) |
                       (~is_byte & ~is_half & (AddrM[1:0] != 2'b00));
   assign off        = AddrM[1:0];
`else
   assign misaligned = 1'b0;
   // Halfwords and words are silently snapped to their natural boundary.
   assign off        = is_byte ? AddrM[1:0] : (is_half ? {AddrM[1], 1'b0} : 2'b00);
`endif

   always_comb begin
      byte_en = 4'b1111;
      wdata   = WriteDataM;
      if (is_byte) begin
         byte_en = 4'b0001 << off;
         wdata   = {4{WriteDataM[7:0]}};
      end else if (is_half) begin
         byte_en = 4'b0011 << off;
         wdata   = {2{WriteDataM[15:0]}};
      end
   end

   assign tmr_tc   = (tmr == 8'd1);
   assign ld_shift = BusRData >> {ld_off, 3'b000};

   always_comb begin
      ld_ext = ld_shift;
      if (ld_byte) begin
         ld_ext = {{24{ld_shift[7] & ~ld_unsigned}}, ld_shift[7:0]};
      end else if (ld_half) begin
         ld_ext = {{16{ld_shift[15] & ~ld_unsigned}}, ld_shift[15:0]};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      StallM    = 1'b0;
      MisalignM = 1'b0;
      BusValid  = 1'b0;
      issue     = 1'b0;
      complete  = 1'b0;
      timeout   = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (misaligned) begin
                  MisalignM = 1'b1;
               end else begin
                  StallM    = 1'b1;
                  issue     = 1'b1;
                  state_nxt = S_REQ;
               end
            end
         end
         S_REQ: begin
            BusValid = 1'b1;
            StallM   = 1'b1;
            if (BusReady) begin
               complete  = 1'b1;
               state_nxt = S_DONE;
            end else if (tmr_tc) begin
               timeout   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         BusWrite    <= 1'b0;
         BusAddr     <= '0;
         BusByteEn   <= '0;
         BusWData    <= '0;
         ReadDataM   <= '0;
         BusErrM     <= 1'b0;
         tmr         <= '0;
         ld_off      <= '0;
         ld_byte     <= 1'b0;
         ld_half     <= 1'b0;
         ld_unsigned <= 1'b0;
      end else begin
         BusErrM <= timeout;
         if (issue) begin
            BusWrite    <= MemWriteM;
            BusAddr     <= {AddrM[31:2], 2'b00};
            BusByteEn   <= byte_en;
            BusWData    <= wdata;
            ld_off      <= off;
            ld_byte     <= is_byte;
            ld_half     <= is_half;
            ld_unsigned <= StrobeM[2];
            tmr         <= TMR_LOAD;
         end else if ((state == S_REQ) && !BusReady && !tmr_tc) begin
            tmr <= tmr - 8'd1;
         end
         if (complete && !BusWrite) begin
            ReadDataM <= ld_ext;
         end else if (timeout) begin
            ReadDataM <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_bus_controller.sv
// Self-checking bench for lsu_bus_controller: directed vector table, hand sequences
// for timeout and reset, then randomized accesses against a byte-level reference model.
module tb_lsu_bus_controller;

   localparam int TO = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        MemReadM = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [2:0]  StrobeM = 3'b000;
   logic [31:0] AddrM = '0;
   logic [31:0] WriteDataM = '0;
   logic [31:0] ReadDataM;
   logic        StallM;
   logic        BusErrM;
   logic        MisalignM;
   logic        BusValid;
   logic        BusWrite;
   logic [31:0] BusAddr;
   logic [3:0]  BusByteEn;
   logic [31:0] BusWData;
   logic        BusReady = 1'b0;
   logic [31:0] BusRData = '0;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] last_rd = '0;

   lsu_bus_controller #(.TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
      .StrobeM(StrobeM), .AddrM(AddrM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .StallM(StallM), .BusErrM(BusErrM), .MisalignM(MisalignM),
      .BusValid(BusValid), .BusWrite(BusWrite), .BusAddr(BusAddr), .BusByteEn(BusByteEn),
      .BusWData(BusWData), .BusReady(BusReady), .BusRData(BusRData)
   );

   always #5 CLK = ~CLK;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        wr;
      logic [2:0]  s;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      int          delay;
      logic [3:0]  be;
      logic [31:0] wdat;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: works in access size and byte lanes rather than bit patterns.
   function automatic int m_size(input logic [2:0] s);
      case (s[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int m_off(input logic [2:0] s, input logic [31:0] a);
      int sz = m_size(s);
      return (int'(a[1:0]) / sz) * sz;
   endfunction

   function automatic logic m_mis(input logic [2:0] s, input logic [31:0] a);
      return (int'(a[1:0]) % m_size(s)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
      logic [3:0] be = '0;
      int o = m_off(s, a);
      for (int i = 0; i < m_size(s); i++) be[o + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] s, input logic [31:0] wd);
      logic [31:0] r;
      int sz = m_size(s);
      for (int lane = 0; lane < 4; lane++) r[8*lane +: 8] = wd[8*(lane % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v = '0;
      int sz = m_size(s);
      int o  = m_off(s, a);
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(o + i) +: 8];
      if (!s[2] && sz < 4 && v[8*sz - 1]) v = v | (32'hFFFF_FFFF << (8*sz));
      return v;
   endfunction

   // One access from IDLE to the IDLE after DONE; BusReady raised in REQ cycle 'delay'
   // (delay >= TO means never). Called from the drive phase just after a rising edge.
   task automatic run_access(input string tag, input logic wr, input logic [2:0] s,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int delay, input logic [3:0] be, input logic [31:0] wdat,
                             input logic [31:0] ld_exp);
      int n;
      logic err;
      logic [31:0] exp_rd;
      @(posedge CLK); #1;
      MemReadM   = !wr;
      MemWriteM  = wr;
      StrobeM    = s;
      AddrM      = a;
      WriteDataM = wd;
      BusReady   = 1'($urandom);
      BusRData   = $urandom;
`ifdef MISALIGN_TRAP_EN
      if (m_mis(s, a)) begin
         @(negedge CLK);
         chk({tag, " misalign_pulse"}, MisalignM, 1'b1);
         chk({tag, " misalign_nostall"}, {BusValid, StallM}, 2'b00);
         @(posedge CLK); #1;
         MemReadM  = 1'b0;
         MemWriteM = 1'b0;
         @(negedge CLK);
         chk({tag, " misalign_after"}, {MisalignM, BusValid, StallM}, 3'b000);
         chk({tag, " misalign_rd_held"}, ReadDataM, last_rd);
         return;
      end
`endif
      @(negedge CLK);
      chk({tag, " detect_stall"}, {StallM, BusValid, MisalignM}, 3'b100);
      err = (delay >= TO);
      n   = err ? TO : delay + 1;
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         BusReady = (i == delay);
         BusRData = BusReady ? rd : $urandom;
         @(negedge CLK);
         chk({tag, " req_valid_stall"}, {BusValid, StallM}, 2'b11);
         if (i == 0) begin
            chk({tag, " bus_addr"}, BusAddr, {a[31:2], 2'b00});
            chk({tag, " bus_write"}, BusWrite, wr);
            chk({tag, " bus_byte_en"}, BusByteEn, be);
            chk({tag, " bus_wdata"}, BusWData, wdat);
         end
      end
      @(posedge CLK); #1;
      BusReady = 1'($urandom);
      BusRData = $urandom;
      exp_rd = err ? 32'h0 : (wr ? last_rd : ld_exp);
      @(negedge CLK);
      chk({tag, " done_nostall"}, {StallM, BusValid}, 2'b00);
      chk({tag, " done_buserr"}, BusErrM, err);
      chk({tag, " done_rdata"}, ReadDataM, exp_rd);
      last_rd = exp_rd;
      @(posedge CLK); #1;
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      BusReady  = 1'b0;
      @(negedge CLK);
      chk({tag, " idle_after"}, {BusErrM, StallM, BusValid}, 3'b000);
      chk({tag, " rdata_held"}, ReadDataM, last_rd);
   endtask

   initial begin
      //                  wr    s       addr          wd            rd           dly  be       wdat          exp_rd
      vecs.push_back(vec_t'{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF});
      vecs.push_back(vec_t'{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 4'b1000, 32'h0,        32'hFFFF_FF80});
      vecs.push_back(vec_t'{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 1, 4'b1000, 32'h0,        32'h0000_0080});
      vecs.push_back(vec_t'{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_FFFF, 0, 4'b1100, 32'h0,        32'h0000_80FF});
      vecs.push_back(vec_t'{1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0,       2, 4'b0010, 32'hABAB_ABAB, 32'h0});
      vecs.push_back(vec_t'{1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h1234_8001, 3, 4'b0011, 32'h0,        32'hFFFF_8001});
      vecs.push_back(vec_t'{1'b1, 3'b001, 32'h0000_0106, 32'h1234_5678, 32'h0,       0, 4'b1100, 32'h5678_5678, 32'h0});
      vecs.push_back(vec_t'{1'b1, 3'b010, 32'h0000_010C, 32'hCAFE_F00D, 32'h0,       1, 4'b1111, 32'hCAFE_F00D, 32'h0});
      vecs.push_back(vec_t'{1'b0, 3'b111, 32'h0000_0110, 32'h0,        32'h89AB_CDEF, 0, 4'b1111, 32'h0,        32'h89AB_CDEF});
      vecs.push_back(vec_t'{1'b0, 3'b010, 32'h0000_0120, 32'h0,        32'h0BAD_CAFE, TO-1, 4'b1111, 32'h0,    32'h0BAD_CAFE});
      vecs.push_back(vec_t'{1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h5566_7788, 0, 4'b1111, 32'h0,        32'h5566_7788});

      #3;
      chk("reset_regs", {BusValid, BusWrite, BusErrM, StallM, MisalignM}, 5'b0);
      chk("reset_bus_addr", BusAddr, 32'h0);
      chk("reset_byte_en_wdata", {28'h0, BusByteEn} | BusWData, 32'h0);
      chk("reset_rdata", ReadDataM, 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0;

      foreach (vecs[k]) begin
         run_access($sformatf("vec%0d", k), vecs[k].wr, vecs[k].s, vecs[k].a, vecs[k].wd,
                    vecs[k].rd, vecs[k].delay, vecs[k].be, vecs[k].wdat, vecs[k].exp_rd);
      end

      // BusReady never arrives: abort after TO REQ cycles, then a clean access.
      run_access("timeout_load", 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1111_2222, 100,
                 4'b1111, 32'h0, 32'h0);
      run_access("after_timeout", 1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'h3333_4444, 0,
                 4'b1111, 32'h0, 32'h3333_4444);
      run_access("timeout_store", 1'b1, 3'b000, 32'h0000_0208, 32'h0000_0011, 32'h0, 100,
                 4'b0001, 32'h1111_1111, 32'h0);

      // Reset mid-REQ together with a pipeline flush.
      @(posedge CLK); #1;
      MemReadM = 1'b1;
      StrobeM  = 3'b010;
      AddrM    = 32'h0000_0300;
      BusReady = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST      = 1'b1;
      MemReadM = 1'b0;
      #1;
      chk("rst_mid_req_valid_stall", {BusValid, StallM}, 2'b00);
      chk("rst_mid_req_regs", {BusErrM, BusWrite, BusByteEn}, 6'b0);
      @(posedge CLK); #1;
      RST     = 1'b0;
      last_rd = '0;
      run_access("after_reset", 1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'h7777_8888, 0,
                 4'b1111, 32'h0, 32'h7777_8888);

      for (int r = 0; r < 40; r++) begin
         logic        wr;
         logic [2:0]  s;
         logic [31:0] a, wd, rd;
         int          dly;
         wr  = 1'($urandom);
         s   = 3'($urandom);
         a   = $urandom;
         wd  = $urandom;
         rd  = $urandom;
         dly = ($urandom_range(0, 9) == 0) ? TO + 4 : int'($urandom_range(0, 4));
         run_access($sformatf("rnd%0d", r), wr, s, a, wd, rd, dly,
                    m_be(s, a), m_wdata(s, wd), m_load(s, a, rd));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
